// File: rtl/usb_pkg.sv
// Shared types and CONTROL register bit positions for the IN-endpoint buffer.
// Endpoint addresses are supplied per instance and are not defined here.
package usb_pkg;

  typedef enum logic [1:0] {
    NAK   = 2'd0,
    STALL = 2'd1,
    DATA0 = 2'd2,
    DATA1 = 2'd3
  } usb_resp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } endpi_state_t;

  localparam int CTRL_READY  = 0;
  localparam int CTRL_STALL  = 1;
  localparam int CTRL_TOGGLE = 2;
  localparam int CTRL_OVF    = 3;
  localparam int CTRL_IRQ    = 7;
  localparam int CTRL_FLUSH  = 15;
  localparam int CTRL_CNT_LO = 8;

endpackage

// File: rtl/usb_endpi_ram.sv
// Payload store: DEPTH x 8 single-clock RAM, one write port and one registered
// read port, so it maps onto block RAM.
module usb_endpi_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/usb_endpi_buffer.sv
// USB IN-endpoint buffer: CPU loads a packet over the I/O bus, SIE IN tokens get
// NAK/STALL/DATAx and the payload is held until ACK. Optional irq: USB_ENDPI_IRQ_EN.
module usb_endpi_buffer
  import usb_pkg::*;
#(
  parameter logic [15:0] CONTROL_ADDR = 16'h5000,
  parameter logic [15:0] DATA_ADDR    = 16'h5002,
  parameter int          MAX_PKT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic        usb_in_req,
  output logic        usb_resp_valid,
  output logic [1:0]  usb_resp,
  output logic [7:0]  usb_tdata,
  output logic        usb_tvalid,
  output logic        usb_tlast,
  input  logic        usb_tready,
  input  logic        usb_ack,
  input  logic        usb_timeout
`ifdef USB_ENDPI_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int         AW      = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam logic [6:0] MAX_CNT = 7'(MAX_PKT);

  endpi_state_t state, state_d;
  usb_resp_t    resp_q, resp_d;
  logic         resp_vld_d;
  logic [6:0]   wptr, rptr, rptr_d;
  logic         ready, stall, toggle, ovf, irq_q;
  logic [7:0]   ram_rdata;
  logic [15:0]  ctrl_word;

  wire ctrl_wr  = io_wr && (io_addr == CONTROL_ADDR);
  wire data_wr  = io_wr && (io_addr == DATA_ADDR);
  wire ctrl_rd  = io_rd && (io_addr == CONTROL_ADDR);
  wire ram_we   = data_wr && !ready && (wptr != MAX_CNT);
  wire last_beat = (rptr == wptr - 7'd1);
  wire ack_acc  = (state == WAIT_ACK) && usb_ack;

  wire unused_wdata = ^io_wdata[14:8];

  // Read address follows the next read pointer so the byte at rptr is always
  // sitting on ram_rdata while streaming.
  usb_endpi_ram #(.DEPTH(MAX_PKT), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr[AW-1:0]),
    .wdata (io_wdata[7:0]),
    .raddr (rptr_d[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state;
    rptr_d     = rptr;
    resp_d     = NAK;
    resp_vld_d = 1'b0;
    case (state)
      IDLE: begin
        if (usb_in_req) begin
          resp_vld_d = 1'b1;
          if (stall)       resp_d = STALL;
          else if (!ready) resp_d = NAK;
          else begin
            resp_d  = toggle ? DATA1 : DATA0;
            state_d = (wptr != 7'd0) ? SEND : WAIT_ACK;
          end
        end
      end
      SEND: begin
        if (usb_tready) begin
          rptr_d = rptr + 7'd1;
          if (last_beat) state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (usb_ack || usb_timeout) begin
          rptr_d  = 7'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_word                        = 16'h0000;
    ctrl_word[CTRL_READY]            = ready;
    ctrl_word[CTRL_STALL]            = stall;
    ctrl_word[CTRL_TOGGLE]           = toggle;
    ctrl_word[CTRL_OVF]              = ovf;
    ctrl_word[CTRL_IRQ]              = irq_q;
    ctrl_word[CTRL_CNT_LO+6:CTRL_CNT_LO] = wptr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rptr           <= 7'd0;
      wptr           <= 7'd0;
      ready          <= 1'b0;
      stall          <= 1'b0;
      toggle         <= 1'b0;
      ovf            <= 1'b0;
      irq_q          <= 1'b0;
      resp_q         <= NAK;
      usb_resp_valid <= 1'b0;
      io_rdata       <= 16'h0000;
    end else begin
      state          <= state_d;
      rptr           <= rptr_d;
      resp_q         <= resp_d;
      usb_resp_valid <= resp_vld_d;
      io_rdata       <= ctrl_rd ? ctrl_word : 16'h0000;

      if (data_wr && !ready) begin
        if (wptr == MAX_CNT) ovf <= 1'b1;
        else                 wptr <= wptr + 7'd1;
      end

      if (ctrl_wr) begin
        stall  <= io_wdata[CTRL_STALL];
        toggle <= io_wdata[CTRL_TOGGLE];
        if (io_wdata[CTRL_READY]) ready <= 1'b1;
        if (io_wdata[CTRL_FLUSH] && !ready) begin
          wptr <= 7'd0;
          ovf  <= 1'b0;
        end
      end

      // Hardware READY clear beats a same-cycle CPU arm; a written TOGGLE beats the flip.
      if (ack_acc) begin
        ready <= 1'b0;
        wptr  <= 7'd0;
        if (!ctrl_wr) toggle <= ~toggle;
      end

`ifdef USB_ENDPI_IRQ_EN
      if (ctrl_wr) irq_q <= 1'b0;
      if (ack_acc) irq_q <= 1'b1;
`else
      irq_q <= 1'b0;
`endif
    end
  end

  assign usb_resp   = resp_q;
  assign usb_tvalid = (state == SEND);
  assign usb_tlast  = (state == SEND) && last_beat;
  assign usb_tdata  = (state == SEND) ? ram_rdata : 8'h00;

`ifdef USB_ENDPI_IRQ_EN
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_usb_endpi_buffer.sv
// Bench for usb_endpi_buffer: directed packet scenarios plus randomized traffic,
// all outputs compared every cycle against a queue-based packet model.
module tb_usb_endpi_buffer;

  localparam logic [15:0] CA   = 16'h5000;
  localparam logic [15:0] DA   = 16'h5002;
  localparam int          MAXP = 64;

  logic        clk, reset;
  logic [15:0] io_addr, io_wdata, io_rdata;
  logic        io_wr, io_rd;
  logic        usb_in_req, usb_resp_valid, usb_tvalid, usb_tlast, usb_tready;
  logic        usb_ack, usb_timeout;
  logic [1:0]  usb_resp;
  logic [7:0]  usb_tdata;
`ifdef USB_ENDPI_IRQ_EN
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  usb_endpi_buffer #(.CONTROL_ADDR(CA), .DATA_ADDR(DA), .MAX_PKT(MAXP)) dut (
    .clk(clk), .reset(reset),
    .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .usb_in_req(usb_in_req), .usb_resp_valid(usb_resp_valid), .usb_resp(usb_resp),
    .usb_tdata(usb_tdata), .usb_tvalid(usb_tvalid), .usb_tlast(usb_tlast), .usb_tready(usb_tready),
    .usb_ack(usb_ack), .usb_timeout(usb_timeout)
`ifdef USB_ENDPI_IRQ_EN
    , .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural packet model ----------------
  logic [7:0]  m_mem[$];
  int          m_idx;
  bit          m_ready, m_stall, m_toggle, m_ovf, m_irq, m_send, m_wait;
  logic        e_rv;
  logic [1:0]  e_resp;
  logic [15:0] e_rdata;

  function automatic logic [15:0] ctrl_word();
    logic ib;
`ifdef USB_ENDPI_IRQ_EN
    ib = m_irq;
`else
    ib = 1'b0;
`endif
    return {1'b0, 7'(m_mem.size()), ib, 3'b000, m_ovf, m_toggle, m_stall, m_ready};
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      m_mem.delete();
      m_idx = 0; m_ready = 0; m_stall = 0; m_toggle = 0; m_ovf = 0; m_irq = 0;
      m_send = 0; m_wait = 0; e_rv = 0; e_resp = 0; e_rdata = 0;
    end else begin : upd
      bit cw, dw, r0, ack_ev, to_ev;
      r0     = m_ready;
      cw     = io_wr && (io_addr == CA);
      dw     = io_wr && (io_addr == DA);
      ack_ev = m_wait && usb_ack;
      to_ev  = m_wait && usb_timeout && !usb_ack;
      e_rdata = (io_rd && io_addr == CA) ? ctrl_word() : 16'h0000;
      e_rv = 0; e_resp = 0;
      if (ack_ev || to_ev) begin
        m_wait = 0; m_idx = 0;
      end else if (!m_send && !m_wait && usb_in_req) begin
        e_rv = 1;
        if (m_stall)       e_resp = 2'd1;
        else if (!m_ready) e_resp = 2'd0;
        else begin
          e_resp = m_toggle ? 2'd3 : 2'd2;
          if (m_mem.size() > 0) m_send = 1; else m_wait = 1;
        end
      end else if (m_send && usb_tready) begin
        m_idx++;
        if (m_idx == m_mem.size()) begin m_send = 0; m_wait = 1; end
      end
      if (dw && !r0) begin
        if (m_mem.size() == MAXP) m_ovf = 1;
        else m_mem.push_back(io_wdata[7:0]);
      end
      if (cw) begin
        m_stall  = io_wdata[1];
        m_toggle = io_wdata[2];
        if (io_wdata[0]) m_ready = 1;
        if (io_wdata[15] && !r0) begin m_mem.delete(); m_ovf = 0; end
        m_irq = 0;
      end
      if (ack_ev) begin
        m_ready = 0;
        if (!cw) m_toggle = !m_toggle;
        m_mem.delete();
        m_irq = 1;
      end
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [7:0] seen[$];
  logic [1:0] last_resp;

  always @(negedge clk) begin
    if (started) begin : cmp
      logic       tv, tl;
      logic [7:0] td;
      tv = m_send;
      tl = m_send && (m_idx == m_mem.size() - 1);
      td = m_send ? m_mem[m_idx] : 8'h00;
      check("cycle_outputs",
            32'({usb_resp_valid, usb_resp, usb_tvalid, usb_tlast, usb_tdata, io_rdata}),
            32'({e_rv, e_resp, tv, tl, td, e_rdata}));
`ifdef USB_ENDPI_IRQ_EN
      check("cycle_irq", 32'(irq), 32'(m_irq));
`endif
      if (usb_resp_valid) last_resp = usb_resp;
      if (usb_tvalid && usb_tready) seen.push_back(usb_tdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_wdata = d; io_wr = 1'b1; tick(1); io_wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [15:0] d);
    io_addr = a; io_rd = 1'b1; tick(1); io_rd = 1'b0; d = io_rdata;
  endtask

  task automatic pulse_in();
    last_resp = 2'bxx; seen.delete();
    usb_in_req = 1'b1; tick(1); usb_in_req = 1'b0;
  endtask

  task automatic pulse_ack();
    usb_ack = 1'b1; tick(1); usb_ack = 1'b0;
  endtask

  task automatic pulse_timeout();
    usb_timeout = 1'b1; tick(1); usb_timeout = 1'b0;
  endtask

  task automatic wait_stream(input string name, input bit rnd);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      usb_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (usb_tvalid && usb_tready && usb_tlast) done = 1;
      tick(1);
    end
    usb_tready = 1'b1;
    check(name, 32'(done), 32'd1);
  endtask

  logic [15:0] rd;
  logic [7:0]  pk[4];

  initial begin
    reset = 1; io_addr = 0; io_wdata = 0; io_wr = 0; io_rd = 0;
    usb_in_req = 0; usb_tready = 1; usb_ack = 0; usb_timeout = 0;
    last_resp = 2'bxx;
    tick(3);
    reset = 0;
    cpu_rd(CA, rd); check("reset_ctrl", 32'(rd), 32'h0000);

    // basic 3-byte packet
    cpu_wr(DA, 16'h0011); cpu_wr(DA, 16'h0022); cpu_wr(DA, 16'h0033);
    cpu_wr(CA, 16'h0001);
    pulse_in();
    wait_stream("t1_stream", 0);
    check("t1_resp", 32'(last_resp), 32'd2);
    check("t1_len", 32'(seen.size()), 32'd3);
    check("t1_b0", 32'(seen[0]), 32'h11);
    check("t1_b1", 32'(seen[1]), 32'h22);
    check("t1_b2", 32'(seen[2]), 32'h33);
    pulse_ack();
    cpu_rd(CA, rd); check("t1_ctrl_after_ack", 32'(rd), 32'h0004);

    // NAK, STALL, zero-length and toggle
    cpu_wr(CA, 16'h0000);
    pulse_in(); tick(1); check("t2_nak", 32'(last_resp), 32'd0);
    cpu_wr(CA, 16'h0003);
    pulse_in(); tick(1); check("t2_stall", 32'(last_resp), 32'd1);
    cpu_wr(CA, 16'h0000);
    cpu_rd(CA, rd); check("t2_ready_sticky", 32'(rd), 32'h0001);
    pulse_in(); tick(1); check("t2_zlp_resp", 32'(last_resp), 32'd2);
    check("t2_zlp_nobytes", 32'(seen.size()), 32'd0);
    pulse_ack();
    cpu_rd(CA, rd); check("t2_toggle_set", 32'(rd), 32'h0004);
    cpu_wr(CA, 16'h0005);
    pulse_in(); tick(1); check("t2_data1", 32'(last_resp), 32'd3);
    pulse_ack();

    // timeout and retransmit
    cpu_wr(DA, 16'h00AA); cpu_wr(DA, 16'h00BB); cpu_wr(CA, 16'h0001);
    pulse_in(); wait_stream("t3_stream1", 0);
    pulse_timeout();
    cpu_rd(CA, rd); check("t3_ctrl_after_to", 32'(rd), 32'h0201);
    pulse_in(); wait_stream("t3_stream2", 0);
    check("t3_resp", 32'(last_resp), 32'd2);
    check("t3_len", 32'(seen.size()), 32'd2);
    check("t3_b0", 32'(seen[0]), 32'hAA);
    check("t3_b1", 32'(seen[1]), 32'hBB);
    pulse_ack();

    // overflow, flush, writes ignored while armed
    cpu_wr(CA, 16'h0000);
    for (int i = 0; i < 65; i++) cpu_wr(DA, 16'(i));
    cpu_rd(CA, rd); check("t4_ovf", 32'(rd), 32'h4008);
    cpu_wr(CA, 16'h8000);
    cpu_rd(CA, rd); check("t4_flush", 32'(rd), 32'h0000);
    cpu_wr(DA, 16'h005A); cpu_wr(CA, 16'h0001); cpu_wr(DA, 16'h0077);
    cpu_rd(CA, rd); check("t4_armed_ignore", 32'(rd), 32'h0101);
    pulse_in(); wait_stream("t4_stream", 0);
    check("t4_b0", 32'(seen[0]), 32'h5A);
    pulse_ack();

    // tready throttling
    for (int i = 0; i < 4; i++) begin
      pk[i] = 8'($urandom);
      cpu_wr(DA, {8'h00, pk[i]});
    end
    cpu_wr(CA, 16'h0001);
    pulse_in(); wait_stream("t5_stream", 1);
    check("t5_len", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t5_byte", 32'(seen[i]), 32'(pk[i]));
    pulse_ack();

    // reset mid-SEND
    for (int i = 0; i < 4; i++) cpu_wr(DA, 16'(i + 1));
    cpu_wr(CA, 16'h0001);
    usb_tready = 1'b0;
    pulse_in(); tick(2);
    check("t6_tvalid_before", 32'(usb_tvalid), 32'd1);
    reset = 1'b1; tick(1);
    check("t6_tvalid_after", 32'(usb_tvalid), 32'd0);
    reset = 1'b0; usb_tready = 1'b1;
    cpu_rd(CA, rd); check("t6_ctrl", 32'(rd), 32'h0000);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      reset      = ($urandom_range(0, 999) < 3);
      io_wr      = ($urandom_range(0, 99) < 35);
      r          = $urandom_range(0, 99);
      io_addr    = (r < 55) ? DA : (r < 85) ? CA : 16'h5004;
      io_wdata   = 16'($urandom);
      if (io_addr == CA) begin
        io_wdata[1]  = ($urandom_range(0, 99) < 10);
        io_wdata[15] = ($urandom_range(0, 99) < 30);
      end
      io_rd       = !io_wr && ($urandom_range(0, 99) < 30);
      usb_in_req  = ($urandom_range(0, 99) < 15);
      usb_ack     = ($urandom_range(0, 99) < 10);
      usb_timeout = ($urandom_range(0, 99) < 10);
      usb_tready  = ($urandom_range(0, 99) < 70);
      tick(1);
    end
    reset = 0; io_wr = 0; io_rd = 0; usb_in_req = 0; usb_ack = 0; usb_timeout = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
